// File: rtl/pc_if.sv
// pc_if: fetch-side request/response bundle between the core pipeline and the PC generator
interface pc_if #(parameter int ADDR_WIDTH = 32);
  logic                  hold_en, jump_en, trap_en, ras_push, ras_pop;
  logic [ADDR_WIDTH-1:0] jump_addr, trap_vec, ras_push_addr, inst_addr;
  logic                  inst_valid, misalign_err, ras_underflow, ras_empty, ras_full;
  modport master (
    output hold_en, jump_en, jump_addr, trap_en, trap_vec, ras_push, ras_push_addr, ras_pop,
    input  inst_addr, inst_valid, misalign_err, ras_underflow, ras_empty, ras_full
  );
  modport slave (
    input  hold_en, jump_en, jump_addr, trap_en, trap_vec, ras_push, ras_push_addr, ras_pop,
    output inst_addr, inst_valid, misalign_err, ras_underflow, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage next-PC generator with trap/jump/stall priority and a circular return-address stack
module pc_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int                    RAS_DEPTH  = 4
) (
  input logic sys_clk,
  input logic sys_rst_n,
  pc_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0]         FULL_CNT = CW'(RAS_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(4);
  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]         ptr, ptr_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  ras_act, do_push, do_pop, underflow_next, misalign_next;
  assign bus.ras_empty = cnt == '0;
  assign bus.ras_full  = cnt == FULL_CNT;
  // RAS only moves when neither a trap nor a stall is in effect
  always_comb begin
    ras_act        = !bus.trap_en && !bus.hold_en;
    do_push        = ras_act && bus.ras_push;
    do_pop         = ras_act && bus.ras_pop && !bus.ras_empty;
    underflow_next = ras_act && bus.ras_pop && bus.ras_empty;
    misalign_next  = !bus.trap_en && bus.jump_en && |bus.jump_addr[1:0];
    pc_next  = bus.trap_en ? {bus.trap_vec[ADDR_WIDTH-1:2], 2'b00} :
               bus.jump_en ? {bus.jump_addr[ADDR_WIDTH-1:2], 2'b00} :
               bus.hold_en ? bus.inst_addr :
               do_pop      ? ras_mem[ptr] : bus.inst_addr + STEP;
    ptr_next = (do_push == do_pop) ? ptr : do_push ? ptr + 1'b1 : ptr - 1'b1;
    cnt_next = bus.trap_en ? '0 : (do_push == do_pop) ? cnt : do_pop ? cnt - 1'b1 :
               bus.ras_full ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      bus.inst_addr     <= RESET_ADDR;
      bus.inst_valid    <= 1'b0;
      bus.misalign_err  <= 1'b0;
      bus.ras_underflow <= 1'b0;
      ptr               <= '0;
      cnt               <= '0;
    end else if (!bus.inst_valid) begin
      bus.inst_valid    <= 1'b1;
      bus.misalign_err  <= 1'b0;
      bus.ras_underflow <= 1'b0;
    end else begin
      bus.inst_addr     <= pc_next;
      bus.misalign_err  <= misalign_next;
      bus.ras_underflow <= underflow_next;
      ptr               <= ptr_next;
      cnt               <= cnt_next;
    end
  // Combined push+pop rewrites the current top in place instead of advancing
  always_ff @(posedge sys_clk)
    if (bus.inst_valid && do_push) ras_mem[do_pop ? ptr : ptr + 1'b1] <= bus.ras_push_addr;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against a queue-based fetch model
module tb_pc_unit;
  localparam int            AW    = 16;
  localparam logic [AW-1:0] RST   = 16'h0100;
  localparam int            DEPTH = 4;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [AW-1:0] m_pc;
  logic m_valid, m_mis, m_unf;
  logic [AW-1:0] ras[$];
  pc_if #(.ADDR_WIDTH(AW)) bus();
  pc_unit #(.ADDR_WIDTH(AW), .RESET_ADDR(RST), .RAS_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus)
  );
  always #5 sys_clk = ~sys_clk;
  function automatic logic [20:0] obs();
    return {bus.inst_addr, bus.inst_valid, bus.misalign_err, bus.ras_underflow, bus.ras_empty, bus.ras_full};
  endfunction
  function automatic logic [20:0] expv();
    return {m_pc, m_valid, m_mis, m_unf, ras.size() == 0, ras.size() == DEPTH};
  endfunction
  task automatic mdl_reset();
    m_pc = RST; m_valid = 1'b0; m_mis = 1'b0; m_unf = 1'b0; ras.delete();
  endtask
  // Reference: stack as a bounded queue, newest at the back
  task automatic mdl_step();
    logic [AW-1:0] pred;
    bit have;
    have = 0;
    pred = '0;
    if (!m_valid) begin
      m_valid = 1'b1; m_mis = 1'b0; m_unf = 1'b0;
      return;
    end
    m_mis = 1'b0; m_unf = 1'b0;
    if (bus.trap_en) begin
      m_pc = bus.trap_vec & ~16'h3;
      ras.delete();
      return;
    end
    if (!bus.hold_en) begin
      if (bus.ras_pop && ras.size() == 0) m_unf = 1'b1;
      if (bus.ras_pop && ras.size() > 0) begin
        pred = ras[ras.size()-1]; have = 1;
        if (bus.ras_push) ras[ras.size()-1] = bus.ras_push_addr;
        else void'(ras.pop_back());
      end else if (bus.ras_push) begin
        ras.push_back(bus.ras_push_addr);
        if (ras.size() > DEPTH) void'(ras.pop_front());
      end
    end
    if (bus.jump_en) begin
      m_pc = bus.jump_addr & ~16'h3;
      m_mis = |bus.jump_addr[1:0];
    end else if (!bus.hold_en) m_pc = have ? pred : m_pc + 16'd4;
  endtask
  task automatic drive(input logic h, j, t, pu, po, input logic [AW-1:0] ja, tv, pa);
    bus.hold_en = h; bus.jump_en = j; bus.trap_en = t; bus.ras_push = pu; bus.ras_pop = po;
    bus.jump_addr = ja; bus.trap_vec = tv; bus.ras_push_addr = pa;
  endtask
  task automatic step();
    @(posedge sys_clk);
    mdl_step();
    @(negedge sys_clk);
  endtask
  task automatic test_reset();
    drive(0, 0, 0, 0, 0, '0, '0, '0);
    mdl_reset();
    #12;
    n_tests++;
    if (obs() !== expv()) begin n_fail++; $display("FAIL reset_hold: got %h want %h", obs(), expv()); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL reset_release[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask
  task automatic test_jump_misalign();
    drive(1, 1, 0, 0, 0, 16'h2002, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL jump_misalign[%0d]: got %h want %h", i, obs(), expv()); end
      drive(0, 0, 0, 0, 0, '0, '0, '0);
    end
  endtask
  task automatic test_hold_trap();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1, 0, 0, 1, 0, '0, '0, 16'h1234);
      else if (i == 3) drive(0, 1, 1, 0, 0, 16'h3000, 16'h0080, '0);
      else drive(0, 0, 0, 0, 0, '0, '0, '0);
      step();
      n_tests++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL hold_trap[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask
  task automatic test_ras_fill_drain();
    for (int i = 0; i < 11; i++) begin
      if (i < 5) drive(0, 0, 0, 1, 0, '0, '0, AW'((i + 1) * 16));
      else if (i < 10) drive(0, 0, 0, 0, 1, '0, '0, '0);
      else drive(0, 0, 0, 0, 0, '0, '0, '0);
      step();
      n_tests++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL ras_fill_drain[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask
  task automatic test_push_pop();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(0, 0, 0, 1, 0, '0, '0, 16'h0500);
        1: drive(0, 0, 0, 1, 1, '0, '0, 16'h099C);
        2: drive(0, 0, 0, 0, 1, '0, '0, '0);
        default: drive(0, 0, 0, 0, 0, '0, '0, '0);
      endcase
      step();
      n_tests++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL push_pop[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask
  task automatic test_wrap();
    drive(0, 1, 0, 0, 0, 16'hFFFC, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL wrap[%0d]: got %h want %h", i, obs(), expv()); end
      drive(0, 0, 0, 0, 0, '0, '0, '0);
    end
  endtask
  task automatic test_async_reset();
    drive(0, 1, 0, 1, 0, 16'h4444, '0, 16'h0777);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 mdl_reset();
    n_tests++;
    if (obs() !== expv()) begin n_fail++; $display("FAIL async_reset: got %h want %h", obs(), expv()); end
    @(negedge sys_clk);
    drive(0, 0, 0, 0, 0, '0, '0, '0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL async_release[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask
  task automatic test_random();
    logic h, j, t, pu, po;
    for (int i = 0; i < 400; i++) begin
      t  = $urandom_range(0, 19) == 0;
      j  = $urandom_range(0, 6) == 0;
      h  = $urandom_range(0, 4) == 0;
      pu = $urandom_range(0, 2) == 0;
      po = $urandom_range(0, 2) == 0;
      if (h && j) begin pu = 1'b0; po = 1'b0; end
      drive(h, j, t, pu, po, AW'($urandom), AW'($urandom), AW'($urandom));
      step();
      n_tests++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL random[%0d]: got %h want %h", i, obs(), expv()); end
    end
  endtask
  initial begin
    test_reset();
    test_jump_misalign();
    test_hold_trap();
    test_ras_fill_drain();
    test_push_pop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the 3-stage RISC-V core's fetch stage.
- Generates the instruction fetch address each cycle. Source priority: trap vector, then resolved jump/branch, then stall hold, then return-address-stack (RAS) prediction, then sequential +4.
- Adds a configurable reset vector, stall support, misaligned-target detection and a small circular RAS for call/return prediction.

Parameters:
- ADDR_WIDTH, 32: width of all address ports and of the PC.
- RESET_ADDR, 0: value loaded into inst_addr on reset. Bits [1:0] must be 0.
- RAS_DEPTH, 4: number of RAS entries. Power of 2, minimum 2.

Ports:
- sys_clk  in  1  clock; all state updates on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- hold_en  in  1  stall; PC and RAS frozen.
- jump_en  in  1  resolved jump/branch redirect from execute.
- jump_addr  in  ADDR_WIDTH  redirect target.
- trap_en  in  1  trap redirect; highest non-reset priority.
- trap_vec  in  ADDR_WIDTH  trap handler address.
- ras_push  in  1  current fetch is a call; push ras_push_addr.
- ras_push_addr  in  ADDR_WIDTH  return address to push.
- ras_pop  in  1  current fetch is a return; predict from RAS top.
- inst_addr  out  ADDR_WIDTH  registered fetch address.
- inst_valid  out  1  inst_addr is a real fetch (not the reset bubble).
- misalign_err  out  1  registered one-cycle pulse: last accepted jump target had bits [1:0] != 0.
- ras_underflow  out  1  registered one-cycle pulse: pop requested with RAS empty.
- ras_empty  out  1  RAS count == 0 (combinational from count register).
- ras_full  out  1  RAS count == RAS_DEPTH.

Behaviour:
- Reset (async assert, sync release on the clock edge):
  - inst_addr = RESET_ADDR; inst_valid = 0; misalign_err = 0; ras_underflow = 0.
  - RAS count = 0 and top pointer = 0. Entry contents are don't-care.
- inst_valid rises on the first rising edge after sys_rst_n deasserts and stays 1 until the next reset. inst_addr is not advanced on that edge; the first fetch is RESET_ADDR.
- Next-PC selection, per edge while inst_valid = 1, first match wins:
  1. trap_en: PC = {trap_vec[ADDR_WIDTH-1:2], 2'b00}. RAS flushed (count = 0). push/pop ignored. Overrides hold_en.
  2. jump_en: PC = {jump_addr[ADDR_WIDTH-1:2], 2'b00}. misalign_err = |jump_addr[1:0] on the next cycle. Overrides hold_en. RAS push/pop still applied as per the RAS rules below (pop has no PC effect).
  3. hold_en: PC unchanged. RAS unchanged. push/pop ignored.
  4. ras_pop with RAS non-empty: PC = top entry.
  5. Otherwise: PC = inst_addr + 4, modulo 2^ADDR_WIDTH (wraps to 0 from all-ones-minus-3).
- misalign_err and ras_underflow are cleared on every edge not setting them. Both are pulses, never sticky.
- RAS rules (applied only when trap_en = 0 and hold_en = 0):
  - Push only: pointer advances mod RAS_DEPTH, entry written. Count increments, saturating at RAS_DEPTH. When full, the oldest entry is silently overwritten.
  - Pop only, non-empty: pointer retreats mod RAS_DEPTH; count decrements.
  - Pop only, empty: no state change; ras_underflow = 1 next cycle; PC falls to sequential (or jump).
  - Push and pop together:
    - Non-empty: predicted PC = old top. Top entry then overwritten with ras_push_addr. Count and pointer unchanged.
    - Empty: treated as push plus underflow pulse.
- Latency: all redirects take effect on the edge where they are sampled, i.e. inst_addr shows the new target in the following cycle. No combinational path from inputs to inst_addr.
- Reset asserted mid-operation: immediate return to reset values regardless of pending jump, trap or stall.

Test Plan:
- Reset with RESET_ADDR = 0x100, release, 3 free cycles → inst_valid 0 then 1; inst_addr 0x100, 0x100, 0x104, 0x108.
- jump_en = 1, jump_addr = 0x2002, hold_en = 1 in the same cycle → next inst_addr = 0x2000; misalign_err pulses 1 for exactly one cycle.
- hold_en = 1 for 3 cycles with ras_push = 1 → inst_addr constant; ras_empty stays 1; then trap_en = 1, trap_vec = 0x80 with jump_en = 1 → inst_addr = 0x80.
- RAS_DEPTH = 4: push 0x10, 0x20, 0x30, 0x40, 0x50 (ras_full after 4th), then pop ×4 → inst_addr 0x50, 0x40, 0x30, 0x20; ras_empty = 1; 5th pop → ras_underflow pulse, inst_addr = previous + 4.
- Simultaneous push 0x99C and pop with top 0x500 → inst_addr = 0x500; next pop → 0x99C; count unchanged by the combined operation.
- ADDR_WIDTH = 16, PC = 0xFFFC, free-run → inst_addr = 0x0000. Assert sys_rst_n low mid-jump → inst_addr = RESET_ADDR immediately, asynchronously.
